serial_receiver_32_w: RTL and testbench

- Receiver for the one-start, 8-data-bit (LSB first), one-stop serial framing; line idles high.
- Oversamples rx at OVS clocks per bit, recovers bytes, and packs four consecutive bytes into a 32-bit word, first byte in [7:0].
- Sits at the far end of the serial link and feeds the control core with bytes and words.
- Detects framing errors and resynchronises after inter-byte gaps.

---
 rtl/serial_receiver_32_w.sv | 164 ++++++++++++++++
 tb/tb_serial_receiver_32_w.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_receiver_32_w.sv
// serial_receiver_32_w
//   Oversampling receiver for 1 start / 8 data (LSB first) / 1 stop framing,
//   line idle high. Recovered bytes are packed four at a time into a 32-bit
//   word, first byte in [7:0]. A partial word is dropped after TIMEOUT_BITS
//   idle bit periods, after a framing error, or on reset.
//
// Parameters
//   OVS          clk cycles per serial bit (even, >= 4)
//   TIMEOUT_BITS idle bit periods before a partial word is discarded
//
// Ports
//   clk        clock
//   reset      synchronous, active-high reset
//   rx         serial line, asynchronous to clk, idle high
//   byte_out   last received byte
//   byte_valid one-cycle pulse, byte_out updated
//   word_out   last assembled word
//   word_valid one-cycle pulse, word_out updated (coincides with byte_valid)
//   frame_err  one-cycle pulse, stop bit sampled low
//   busy       high while a frame is in progress (state != IDLE)
module serial_receiver_32_w #(
  parameter int unsigned OVS          = 8,
  parameter int unsigned TIMEOUT_BITS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic [31:0] word_out,
  output logic        word_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int unsigned SW     = $clog2(OVS);
  localparam int unsigned TMO_N  = TIMEOUT_BITS * OVS;
  localparam int unsigned TW     = $clog2(TMO_N);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVS - 1);
  localparam logic [SW-1:0] HALF_LAST = SW'(OVS / 2 - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TMO_N - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t          state, state_next;
  logic            rs1, rs;
  logic [SW-1:0]   samp;
  logic [2:0]      bit_cnt;
  logic [1:0]      byte_index;
  logic [TW-1:0]   tmo;
  logic [7:0]      shift;
  logic [7:0]      lane0, lane1, lane2;
  logic            samp_hit;

  // Two-flop synchroniser; idle-high reset value keeps IDLE quiet after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rs1 <= 1'b1;
      rs  <= 1'b1;
    end else begin
      rs1 <= rx;
      rs  <= rs1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // samp_hit marks the cycle on which rs is sampled in START/DATA/STOP.
  always_comb begin
    state_next = state;
    samp_hit   = 1'b0;
    unique case (state)
      IDLE:  if (!rs) state_next = START;
      START: if (samp == HALF_LAST) begin
               samp_hit   = 1'b1;
               state_next = rs ? IDLE : DATA;
             end
      DATA:  if (samp == SAMP_LAST) begin
               samp_hit = 1'b1;
               if (bit_cnt == 3'd7) state_next = STOP;
             end
      STOP:  if (samp == SAMP_LAST) begin
               samp_hit   = 1'b1;
               state_next = rs ? IDLE : BREAK;
             end
      BREAK: if (rs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      samp       <= '0;
      bit_cnt    <= '0;
      byte_index <= '0;
      tmo        <= '0;
      shift      <= '0;
      lane0      <= '0;
      lane1      <= '0;
      lane2      <= '0;
      byte_out   <= '0;
      word_out   <= '0;
      byte_valid <= 1'b0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (state == IDLE || state == BREAK || samp_hit) samp <= '0;
      else                                            samp <= samp + 1'b1;

      if (state == START && samp_hit) bit_cnt <= '0;

      if (state == DATA && samp_hit) begin
        shift   <= {rs, shift[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (state == STOP && samp_hit) begin
        if (rs) begin
          byte_out   <= shift;
          byte_valid <= 1'b1;
          byte_index <= byte_index + 1'b1;
          unique case (byte_index)
            2'd0: lane0 <= shift;
            2'd1: lane1 <= shift;
            2'd2: lane2 <= shift;
            2'd3: begin
              word_out   <= {shift, lane2, lane1, lane0};
              word_valid <= 1'b1;
            end
            default: ;
          endcase
        end else begin
          // Lanes are simply overwritten later; resetting the index is enough
          // to discard the partial word.
          frame_err  <= 1'b1;
          byte_index <= '0;
        end
      end

      // Idle timeout only runs while a partial word is pending; leaving IDLE
      // restarts it.
      if (state == IDLE && state_next == IDLE && byte_index != 2'd0) begin
        if (tmo == TMO_LAST) begin
          tmo        <= '0;
          byte_index <= '0;
        end else begin
          tmo <= tmo + 1'b1;
        end
      end else begin
        tmo <= '0;
      end
    end
  end

endmodule

// File: tb/tb_serial_receiver_32_w.sv
// tb_serial_receiver_32_w
//   Self-checking bench for serial_receiver_32_w: a directed vector table,
//   hand-written corner sequences (glitch, reset mid-frame, latency) and a
//   randomized section scored against a byte/word queue model.
`timescale 1ns/1ps
module tb_serial_receiver_32_w;

  localparam int OVS          = 8;
  localparam int TIMEOUT_BITS = 16;
  localparam int CLK_NS       = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic [31:0] word_out;
  logic        word_valid;
  logic        frame_err;
  logic        busy;

  serial_receiver_32_w #(.OVS(OVS), .TIMEOUT_BITS(TIMEOUT_BITS)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .word_out   (word_out),
    .word_valid (word_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #(CLK_NS/2) clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pulse monitor: sole writer of these counters.
  int   n_bv = 0, n_wv = 0, n_err = 0, n_bad = 0;
  logic prev_bv = 1'b0;
  time  t_bv = 0;

  always @(negedge clk) begin
    if (byte_valid) begin
      n_bv++;
      t_bv = $time;
      if (prev_bv) n_bad++;
    end
    if (word_valid) begin
      n_wv++;
      if (!byte_valid) n_bad++;
    end
    if (frame_err) begin
      n_err++;
      if (byte_valid) n_bad++;
    end
    prev_bv = byte_valid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  d;
    bit          ok;
    int          low;
    int          gap;
    int          bv;
    logic [7:0]  b;
    int          wv;
    logic [31:0] w;
    int          err;
  } vec_t;

  time t_fall;

  // Idle for gap bit periods, transmit one frame, then compare the pulses
  // seen during the frame and the held outputs afterwards.
  task automatic run_frame(input logic [7:0] d, input bit ok, input int low, input int gap,
                           input int ebv, input logic [7:0] eb, input int ewv,
                           input logic [31:0] ew, input int eerr);
    int b0, w0, e0, p0;
    rx = 1'b1;
    repeat (gap * OVS) @(negedge clk);
    chk("busy_before_frame", 32'(busy), 32'd0);
    b0 = n_bv; w0 = n_wv; e0 = n_err; p0 = n_bad;
    t_fall = $time;
    rx = 1'b0;
    repeat (OVS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (OVS) @(negedge clk);
    end
    rx = ok;
    repeat (OVS) @(negedge clk);
    if (!ok) begin
      repeat (low * OVS) @(negedge clk);
      rx = 1'b1;
    end
    chk("byte_valid_count", 32'(n_bv - b0), 32'(ebv));
    chk("byte_out", 32'(byte_out), 32'(eb));
    chk("word_valid_count", 32'(n_wv - w0), 32'(ewv));
    chk("word_out", word_out, ew);
    chk("frame_err_count", 32'(n_err - e0), 32'(eerr));
    chk("pulse_shape", 32'(n_bad - p0), 32'd0);
  endtask

  vec_t tbl[13];

  initial begin
    #(2ms);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  model_byte;
    logic [31:0] model_word;
    logic [7:0]  lanes[$];
    int          gaps[7];
    bit          prev_bad;
    int          b0, e0;

    tbl[0]  = '{8'hA5, 1'b1, 0,  2, 1, 8'hA5, 0, 32'h0000_0000, 0};
    tbl[1]  = '{8'h78, 1'b1, 0, 20, 1, 8'h78, 0, 32'h0000_0000, 0};
    tbl[2]  = '{8'h56, 1'b1, 0,  0, 1, 8'h56, 0, 32'h0000_0000, 0};
    tbl[3]  = '{8'h34, 1'b1, 0,  0, 1, 8'h34, 0, 32'h0000_0000, 0};
    tbl[4]  = '{8'h12, 1'b1, 0,  0, 1, 8'h12, 1, 32'h1234_5678, 0};
    tbl[5]  = '{8'h11, 1'b1, 0,  2, 1, 8'h11, 0, 32'h1234_5678, 0};
    tbl[6]  = '{8'h22, 1'b1, 0,  0, 1, 8'h22, 0, 32'h1234_5678, 0};
    tbl[7]  = '{8'h44, 1'b1, 0, 17, 1, 8'h44, 0, 32'h1234_5678, 0};
    tbl[8]  = '{8'h33, 1'b1, 0,  0, 1, 8'h33, 0, 32'h1234_5678, 0};
    tbl[9]  = '{8'h22, 1'b1, 0,  0, 1, 8'h22, 0, 32'h1234_5678, 0};
    tbl[10] = '{8'h11, 1'b1, 0,  0, 1, 8'h11, 1, 32'h1122_3344, 0};
    tbl[11] = '{8'h3C, 1'b0, 20, 2, 0, 8'h11, 0, 32'h1122_3344, 1};
    tbl[12] = '{8'h5A, 1'b1, 0,  2, 1, 8'h5A, 0, 32'h1122_3344, 0};

    rx    = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_byte_out",   32'(byte_out),   32'd0);
    chk("reset_word_out",   word_out,        32'd0);
    chk("reset_byte_valid", 32'(byte_valid), 32'd0);
    chk("reset_word_valid", 32'(word_valid), 32'd0);
    chk("reset_frame_err",  32'(frame_err),  32'd0);
    chk("reset_busy",       32'(busy),       32'd0);
    reset = 1'b0;

    // Directed table: single byte, back-to-back word, timeout, framing error.
    for (int i = 0; i < 13; i++) begin
      run_frame(tbl[i].d, tbl[i].ok, tbl[i].low, tbl[i].gap,
                tbl[i].bv, tbl[i].b, tbl[i].wv, tbl[i].w, tbl[i].err);
      if (i == 0)
        chk("latency_clk", 32'(int'((t_bv - t_fall) / CLK_NS)), 32'(OVS * 19 / 2 + 3));
    end

    // Short low glitch on rx must be rejected at the start-bit sample.
    rx = 1'b1;
    repeat (2 * OVS) @(negedge clk);
    b0 = n_bv; e0 = n_err;
    rx = 1'b0;
    repeat (OVS / 2 - 2) @(negedge clk);
    rx = 1'b1;
    repeat (OVS + 3) @(negedge clk);
    chk("glitch_busy", 32'(busy), 32'd0);
    chk("glitch_byte_valid", 32'(n_bv - b0), 32'd0);
    chk("glitch_frame_err", 32'(n_err - e0), 32'd0);

    // Reset during bit 4 of the third byte of a word.
    run_frame(8'hA1, 1'b1, 0, 20, 1, 8'hA1, 0, 32'h1122_3344, 0);
    run_frame(8'hB2, 1'b1, 0,  0, 1, 8'hB2, 0, 32'h1122_3344, 0);
    rx = 1'b0;
    repeat (OVS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      repeat (OVS) @(negedge clk);
    end
    rx = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_mid_frame", 32'(busy), 32'd1);
    b0 = n_bv; e0 = n_err;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_byte_out", 32'(byte_out), 32'd0);
    chk("abort_word_out", word_out, 32'd0);
    repeat (4 * OVS) @(negedge clk);
    chk("abort_no_byte_valid", 32'(n_bv - b0), 32'd0);
    chk("abort_no_frame_err", 32'(n_err - e0), 32'd0);
    run_frame(8'h01, 1'b1, 0, 0, 1, 8'h01, 0, 32'h0000_0000, 0);
    run_frame(8'h02, 1'b1, 0, 0, 1, 8'h02, 0, 32'h0000_0000, 0);
    run_frame(8'h03, 1'b1, 0, 0, 1, 8'h03, 0, 32'h0000_0000, 0);
    run_frame(8'h04, 1'b1, 0, 0, 1, 8'h04, 1, 32'h0403_0201, 0);

    // Randomized frames against a queue model: bytes accumulate in arrival
    // order, four make a word; a long idle gap or a bad stop bit empties it.
    gaps = '{0, 1, 2, 3, 8, 20, 25};
    model_byte = 8'h04;
    model_word = 32'h0403_0201;
    prev_bad   = 1'b0;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      bit         ok;
      int         low, gap, ewv;
      d   = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 9) != 0);
      low = $urandom_range(1, 4);
      gap = gaps[$urandom_range(0, 6)];
      if (prev_bad && gap == 0) gap = 1;
      if (gap >= TIMEOUT_BITS) lanes.delete();
      ewv = 0;
      if (ok) begin
        model_byte = d;
        lanes.push_back(d);
        if (lanes.size() == 4) begin
          model_word = {lanes[3], lanes[2], lanes[1], lanes[0]};
          ewv = 1;
          lanes.delete();
        end
      end else begin
        lanes.delete();
      end
      run_frame(d, ok, low, gap, ok ? 1 : 0, model_byte, ewv, model_word, ok ? 0 : 1);
      prev_bad = !ok;
    end

    rx = 1'b1;
    repeat (2 * OVS) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
